// File: rtl/sdram_resp_pkg.sv
// Shared types and helpers for the SDR SDRAM device responder.
// Command decode from the raw {cs_n, ras_n, cas_n, we_n} pins plus CAS-latency bounds.
package sdram_resp_pkg;

  localparam int unsigned CL_W   = 3;
  localparam int unsigned PIPE_D = 3;
  localparam logic [CL_W-1:0] CL_MIN = CL_W'(2);
  localparam logic [CL_W-1:0] CL_MAX = CL_W'(3);

  typedef enum logic [2:0] {NOP, ACT, READ, WRITE, PRE, REF, LMR, BST} cmd_e;

  function automatic cmd_e decode_cmd(input logic [3:0] pins);
    cmd_e c;
    c = NOP;
    if (!pins[3]) begin
      case (pins[2:0])
        3'b011:  c = ACT;
        3'b101:  c = READ;
        3'b100:  c = WRITE;
        3'b010:  c = PRE;
        3'b001:  c = REF;
        3'b000:  c = LMR;
        3'b110:  c = BST;
        default: c = NOP;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/sdram_resp_mem.sv
// Single-port backing RAM for the SDRAM responder: byte-enable write, registered read.
module sdram_resp_mem #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 32,
  parameter int unsigned BW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic [BW-1:0] be,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < int'(BW); i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sdram_responder.sv
// SDR SDRAM device-side responder: command decode, per-bank rows, CL-deep read pipeline.
// Optional protocol checker enabled by defining SDRAM_RESP_CHECK_EN.
module sdram_responder
  import sdram_resp_pkg::*;
#(
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned BA_W    = 2,
  parameter int unsigned DQ_W    = 32,
  parameter int unsigned DQM_W   = 4,
  parameter int unsigned COL_W   = 10,
  parameter int unsigned MEM_AW  = 12,
  parameter int unsigned CAS_LAT = 3
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic [ADDR_W-1:0]    sdram_addr,
  input  logic [BA_W-1:0]      sdram_ba,
  input  logic                 sdram_cas_n,
  input  logic                 sdram_cke,
  input  logic                 sdram_cs_n,
  inout  wire  [DQ_W-1:0]      sdram_dq,
  input  logic [DQM_W-1:0]     sdram_dqm,
  input  logic                 sdram_ras_n,
  input  logic                 sdram_we_n,
  output logic [2**BA_W-1:0]   bank_open,
  output logic                 proto_err
);

  localparam int unsigned NB = 2**BA_W;

  cmd_e              cmd_c;
  logic [ADDR_W-1:0] row_q [NB];
  logic [ADDR_W-1:0] row_d [NB];
  logic [NB-1:0]     open_q, open_d;
  logic [CL_W-1:0]   cl_q, cl_d;
  logic [PIPE_D-1:0] vld_q, vld_d;
  logic [DQ_W-1:0]   dat1_q, dat1_d, dat2_q, dat2_d;
  logic [DQ_W-1:0]   mem_rdata;
  logic [MEM_AW-1:0] mem_addr_c;
  logic              mem_we_c, mem_re_c, cl3_c, dq_oe_c;
  logic [DQ_W-1:0]   dq_out_c;

  assign cmd_c      = decode_cmd({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n});
  assign mem_addr_c = MEM_AW'({sdram_ba, row_q[sdram_ba], sdram_addr[COL_W-1:0]});
  assign mem_we_c   = sdram_cke && (cmd_c == WRITE);
  assign mem_re_c   = sdram_cke && (cmd_c == READ);
  assign cl3_c      = (cl_q == CL_MAX);

  sdram_resp_mem #(
    .AW (MEM_AW),
    .DW (DQ_W),
    .BW (DQM_W)
  ) u_mem (
    .clk   (clk_clk),
    .we    (mem_we_c),
    .re    (mem_re_c),
    .addr  (mem_addr_c),
    .wdata (sdram_dq),
    .be    (~sdram_dqm),
    .rdata (mem_rdata)
  );

  // Command execution; everything, including the read pipeline, holds while cke is low.
  always_comb begin
    row_d  = row_q;
    open_d = open_q;
    cl_d   = cl_q;
    vld_d  = vld_q;
    dat1_d = dat1_q;
    dat2_d = dat2_q;
    if (sdram_cke) begin
      vld_d  = {vld_q[1] & cl3_c, vld_q[0], 1'b0};
      dat1_d = mem_rdata;
      dat2_d = dat1_q;
      case (cmd_c)
        ACT: begin
          row_d[sdram_ba]  = sdram_addr;
          open_d[sdram_ba] = 1'b1;
        end
        READ: begin
          vld_d[0] = 1'b1;
          if (sdram_addr[10]) open_d[sdram_ba] = 1'b0;
        end
        WRITE: begin
          vld_d = '0;
          if (sdram_addr[10]) open_d[sdram_ba] = 1'b0;
        end
        PRE: begin
          if (sdram_addr[10]) open_d = '0;
          else                open_d[sdram_ba] = 1'b0;
        end
        LMR: begin
          if (sdram_addr[6:4] == CL_MIN || sdram_addr[6:4] == CL_MAX) cl_d = sdram_addr[6:4];
        end
        BST:     vld_d = '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      for (int i = 0; i < int'(NB); i++) row_q[i] <= '0;
      open_q <= '0;
      cl_q   <= CL_W'(CAS_LAT);
      vld_q  <= '0;
      dat1_q <= '0;
      dat2_q <= '0;
    end else begin
      row_q  <= row_d;
      open_q <= open_d;
      cl_q   <= cl_d;
      vld_q  <= vld_d;
      dat1_q <= dat1_d;
      dat2_q <= dat2_d;
    end
  end

  // The last pipeline stage selected by CL owns the bus for exactly one cycle.
  assign dq_oe_c   = cl3_c ? vld_q[2] : vld_q[1];
  assign dq_out_c  = cl3_c ? dat2_q : dat1_q;
  assign sdram_dq  = dq_oe_c ? dq_out_c : 'z;
  assign bank_open = open_q;

`ifdef SDRAM_RESP_CHECK_EN
  logic perr_q, perr_d;

  always_comb begin
    perr_d = perr_q;
    if (sdram_cke) begin
      case (cmd_c)
        ACT:   if (open_q[sdram_ba]) perr_d = 1'b1;
        READ:  if (!open_q[sdram_ba]) perr_d = 1'b1;
        WRITE: if (!open_q[sdram_ba] || (|vld_q)) perr_d = 1'b1;
        LMR: begin
          if ((|open_q) || !(sdram_addr[6:4] == CL_MIN || sdram_addr[6:4] == CL_MAX))
            perr_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) perr_q <= 1'b0;
    else             perr_q <= perr_d;
  end

  assign proto_err = perr_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_responder.sv
// Directed self-checking bench for sdram_responder; inputs change and dq is sampled on negedges.
module tb_sdram_responder;

  localparam logic [2:0] C_NOP = 3'b111;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_LMR = 3'b000;
  localparam logic [31:0] IDLE_PAT = 32'h5A5A_C3C3;
`ifdef SDRAM_RESP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, cke, cs_n, ras_n, cas_n, we_n;
  logic [12:0] addr;
  logic [1:0]  ba;
  logic [3:0]  dqm;
  logic        tb_oe;
  logic [31:0] tb_wdata;
  wire  [31:0] dq;
  logic [3:0]  bank_open;
  logic        proto_err;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  assign dq = tb_oe ? tb_wdata : 'z;

  sdram_responder dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .sdram_addr  (addr),
    .sdram_ba    (ba),
    .sdram_cas_n (cas_n),
    .sdram_cke   (cke),
    .sdram_cs_n  (cs_n),
    .sdram_dq    (dq),
    .sdram_dqm   (dqm),
    .sdram_ras_n (ras_n),
    .sdram_we_n  (we_n),
    .bank_open   (bank_open),
    .proto_err   (proto_err)
  );

  // Apply one command for the next rising edge, then move to the following negedge.
  task automatic step(input logic [2:0] rcw, input logic [1:0] b, input logic [12:0] a,
                      input logic [3:0] m, input logic [31:0] wd, input bit drive);
    cs_n = 1'b0;
    {ras_n, cas_n, we_n} = rcw;
    ba = b;
    addr = a;
    dqm = m;
    tb_wdata = wd;
    tb_oe = drive;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(C_NOP, 2'd0, 13'd0, 4'h0, IDLE_PAT, 1'b1);
    step(C_NOP, 2'd0, 13'd0, 4'h0, IDLE_PAT, 1'b1);
    rst = 1'b0;
    n_checks++;
    if (bank_open !== 4'h0) begin
      n_fail++; $display("FAIL reset_bank_open got=%h exp=0", bank_open);
    end
    n_checks++;
    if (proto_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_proto_err got=%b exp=0", proto_err);
    end
    step(C_NOP, 2'd0, 13'd0, 4'h0, IDLE_PAT, 1'b1);
    n_checks++;
    if (dq !== IDLE_PAT) begin
      n_fail++; $display("FAIL reset_dq_hiz got=%h exp=%h", dq, IDLE_PAT);
    end
  endtask

  task automatic test_basic_rw;
    logic [31:0] exp;
    step(C_ACT, 2'd0, 13'd5, 4'h0, IDLE_PAT, 1'b1);
    n_checks++;
    if (bank_open !== 4'b0001) begin
      n_fail++; $display("FAIL act_b0 got=%b exp=0001", bank_open);
    end
    step(C_WR, 2'd0, 13'd3, 4'h0, 32'hDEAD_BEEF, 1'b1);
    step(C_RD, 2'd0, 13'd3, 4'h0, IDLE_PAT, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      exp = (k == 3) ? 32'hDEAD_BEEF : IDLE_PAT;
      n_checks++;
      if (dq !== exp) begin
        n_fail++; $display("FAIL cl3_read k=%0d got=%h exp=%h", k, dq, exp);
      end
      step(C_NOP, 2'd0, 13'd0, 4'h0, IDLE_PAT, (k + 1) != 3);
    end
  endtask

  task automatic test_cl2_mask;
    logic [31:0] exp;
    step(C_PRE, 2'd0, 13'h400, 4'h0, IDLE_PAT, 1'b1);
    n_checks++;
    if (bank_open !== 4'h0) begin
      n_fail++; $display("FAIL pre_all got=%b exp=0000", bank_open);
    end
    step(C_LMR, 2'd0, 13'h020, 4'h0, IDLE_PAT, 1'b1);
    step(C_ACT, 2'd0, 13'd5, 4'h0, IDLE_PAT, 1'b1);
    step(C_WR, 2'd0, 13'd7, 4'h0, 32'h1122_3344, 1'b1);
    step(C_WR, 2'd0, 13'd7, 4'b0101, 32'hAABB_CCDD, 1'b1);
    step(C_RD, 2'd0, 13'd7, 4'h0, IDLE_PAT, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      exp = (k == 2) ? 32'hAA22_CC44 : IDLE_PAT;
      n_checks++;
      if (dq !== exp) begin
        n_fail++; $display("FAIL cl2_mask_read k=%0d got=%h exp=%h", k, dq, exp);
      end
      step(C_NOP, 2'd0, 13'd0, 4'h0, IDLE_PAT, (k + 1) != 2);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0]  cmd_a [8] = '{C_RD, C_RD, C_NOP, C_NOP, C_RD, C_RD, C_NOP, C_NOP};
    logic [12:0] col_a [8] = '{13'd0, 13'd1, 13'd0, 13'd0, 13'd2, 13'd3, 13'd0, 13'd0};
    bit          cke_a [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    bit          vld_a [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] dat_a [8] = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd2, 32'd3, 32'd4, 32'd0};
    logic [31:0] exp;
    for (int c = 0; c < 4; c++) step(C_WR, 2'd0, 13'(c), 4'h0, 32'(c + 1), 1'b1);
    step(C_NOP, 2'd0, 13'd0, 4'h0, IDLE_PAT, 1'b1);
    for (int k = 0; k < 8; k++) begin
      cke = cke_a[k];
      step(cmd_a[k], 2'd0, col_a[k], 4'h0, IDLE_PAT, !vld_a[k]);
      exp = vld_a[k] ? dat_a[k] : IDLE_PAT;
      n_checks++;
      if (dq !== exp) begin
        n_fail++; $display("FAIL b2b_stream k=%0d got=%h exp=%h", k, dq, exp);
      end
    end
    cke = 1'b1;
  endtask

  task automatic test_read_then_write;
    logic [31:0] exp;
    step(C_RD, 2'd0, 13'd0, 4'h0, IDLE_PAT, 1'b1);
    n_checks++;
    if (dq !== IDLE_PAT) begin
      n_fail++; $display("FAIL rw_collide_n1 got=%h exp=%h", dq, IDLE_PAT);
    end
    step(C_WR, 2'd0, 13'd5, 4'h0, 32'hCAFE_0000, 1'b1);
    n_checks++;
    if (dq !== 32'hCAFE_0000) begin
      n_fail++; $display("FAIL rw_collide_flush got=%h exp=cafe0000", dq);
    end
    step(C_NOP, 2'd0, 13'd0, 4'h0, IDLE_PAT, 1'b1);
    n_checks++;
    if (dq !== IDLE_PAT) begin
      n_fail++; $display("FAIL rw_collide_n3 got=%h exp=%h", dq, IDLE_PAT);
    end
    step(C_RD, 2'd0, 13'd5, 4'h0, IDLE_PAT, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      exp = (k == 2) ? 32'hCAFE_0000 : IDLE_PAT;
      n_checks++;
      if (dq !== exp) begin
        n_fail++; $display("FAIL rw_write_landed k=%0d got=%h exp=%h", k, dq, exp);
      end
      step(C_NOP, 2'd0, 13'd0, 4'h0, IDLE_PAT, (k + 1) != 2);
    end
    n_checks++;
    if (proto_err !== CHK) begin
      n_fail++; $display("FAIL rw_proto_err got=%b exp=%b", proto_err, CHK);
    end
    rst = 1'b1;
    step(C_NOP, 2'd0, 13'd0, 4'h0, IDLE_PAT, 1'b1);
    rst = 1'b0;
    n_checks++;
    if (proto_err !== 1'b0 || bank_open !== 4'h0) begin
      n_fail++; $display("FAIL rw_reset_clear got=%b/%b exp=0/0000", proto_err, bank_open);
    end
  endtask

  task automatic test_auto_precharge;
    logic [31:0] exp;
    step(C_ACT, 2'd1, 13'd9, 4'h0, IDLE_PAT, 1'b1);
    n_checks++;
    if (bank_open !== 4'b0010) begin
      n_fail++; $display("FAIL act_b1 got=%b exp=0010", bank_open);
    end
    step(C_RD, 2'd1, 13'h400, 4'h0, IDLE_PAT, 1'b1);
    n_checks++;
    if (bank_open !== 4'b0000) begin
      n_fail++; $display("FAIL read_autopre got=%b exp=0000", bank_open);
    end
    // Row 9 col 0 aliases RAM word 0x400, written with 1 before the reset.
    for (int k = 1; k <= 5; k++) begin
      exp = (k == 3) ? 32'd1 : IDLE_PAT;
      n_checks++;
      if (dq !== exp) begin
        n_fail++; $display("FAIL cl_reset_read k=%0d got=%h exp=%h", k, dq, exp);
      end
      step(C_NOP, 2'd0, 13'd0, 4'h0, IDLE_PAT, (k + 1) != 3);
    end
    step(C_ACT, 2'd0, 13'd0, 4'h0, IDLE_PAT, 1'b1);
    step(C_ACT, 2'd2, 13'd5, 4'h0, IDLE_PAT, 1'b1);
    n_checks++;
    if (bank_open !== 4'b0101) begin
      n_fail++; $display("FAIL act_b0_b2 got=%b exp=0101", bank_open);
    end
    step(C_PRE, 2'd0, 13'h400, 4'h0, IDLE_PAT, 1'b1);
    n_checks++;
    if (bank_open !== 4'b0000) begin
      n_fail++; $display("FAIL pre_all_b0_b2 got=%b exp=0000", bank_open);
    end
  endtask

  task automatic test_closed_bank;
    logic [31:0] exp;
    step(C_RD, 2'd2, 13'd0, 4'h0, IDLE_PAT, 1'b1);
    n_checks++;
    if (proto_err !== CHK) begin
      n_fail++; $display("FAIL closed_read_err got=%b exp=%b", proto_err, CHK);
    end
    for (int k = 1; k <= 5; k++) begin
      exp = (k == 3) ? 32'd1 : IDLE_PAT;
      n_checks++;
      if (dq !== exp) begin
        n_fail++; $display("FAIL closed_read_data k=%0d got=%h exp=%h", k, dq, exp);
      end
      step(C_NOP, 2'd0, 13'd0, 4'h0, IDLE_PAT, (k + 1) != 3);
    end
    n_checks++;
    if (proto_err !== CHK) begin
      n_fail++; $display("FAIL closed_err_sticky got=%b exp=%b", proto_err, CHK);
    end
    rst = 1'b1;
    step(C_NOP, 2'd0, 13'd0, 4'h0, IDLE_PAT, 1'b1);
    rst = 1'b0;
    n_checks++;
    if (proto_err !== 1'b0) begin
      n_fail++; $display("FAIL closed_err_reset got=%b exp=0", proto_err);
    end
  endtask

  initial begin
    rst = 1'b1;
    cke = 1'b1;
    cs_n = 1'b1;
    {ras_n, cas_n, we_n} = C_NOP;
    addr = '0;
    ba = '0;
    dqm = '0;
    tb_oe = 1'b1;
    tb_wdata = IDLE_PAT;
    @(negedge clk);
    test_reset();
    test_basic_rw();
    test_cl2_mask();
    test_back_to_back();
    n_checks++;
    if (proto_err !== 1'b0) begin
      n_fail++; $display("FAIL no_false_err got=%b exp=0", proto_err);
    end
    test_read_then_write();
    test_auto_precharge();
    test_closed_bank();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
